// File: rtl/tx_code_group_ctrl.sv
// 1000BASE-X PCS transmit code-group sequencer between TRANSMIT and ENCODE; one registered code-group per GTX_CLK.
// `define TXCG_CONFIG_EN to add /C/ (CONFIG) ordered sets; otherwise CONFIG requests are sent as /V/.
module tx_code_group_ctrl #(
  parameter logic [7:0] I1_DATA = 8'hC5,
  parameter logic [7:0] I2_DATA = 8'h50,
  parameter int         CFG_W   = 16
) (
  input  logic             GTX_CLK,
  input  logic             mr_main_reset,
  input  logic [2:0]       tx_o_set,
  input  logic [7:0]       TXD,
  input  logic             rd_pos,
  input  logic [CFG_W-1:0] cfg_reg,
  output logic [7:0]       enc_data,
  output logic             enc_k,
  output logic             tx_even,
  output logic             TX_OSET_indicate
);

  localparam logic [2:0] OS_IDLE = 3'd0, OS_S = 3'd1, OS_T = 3'd2, OS_R = 3'd3,
                         OS_V = 3'd4, OS_DATA = 3'd5, OS_CONFIG = 3'd6;
  localparam logic [7:0] K28_5 = 8'hBC, K27_7 = 8'hFB, K29_7 = 8'hFD,
                         K23_7 = 8'hF7, K30_7 = 8'hFE, D21_5 = 8'hB5, D2_2 = 8'h42;

  typedef enum logic [2:0] {
    GEN, IDLE_K, IDLE_D
`ifdef TXCG_CONFIG_EN
    , CFG_K, CFG_D, CFG_LO, CFG_HI
`endif
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] data_nxt;
  logic       k_nxt, ind_nxt;
  logic       rd_lat, rd_lat_nxt;

`ifdef TXCG_CONFIG_EN
  logic [CFG_W-1:0] cfg_lat, cfg_lat_nxt;
  logic             cfg_toggle, cfg_toggle_nxt;
`else
  wire unused_cfg = ^cfg_reg;
`endif

  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state            <= GEN;
      enc_data         <= 8'h00;
      enc_k            <= 1'b0;
      tx_even          <= 1'b0;
      TX_OSET_indicate <= 1'b1;
      rd_lat           <= 1'b0;
`ifdef TXCG_CONFIG_EN
      cfg_lat          <= '0;
      cfg_toggle       <= 1'b0;
`endif
    end else begin
      state            <= state_nxt;
      enc_data         <= data_nxt;
      enc_k            <= k_nxt;
      tx_even          <= ~tx_even;
      TX_OSET_indicate <= ind_nxt;
      rd_lat           <= rd_lat_nxt;
`ifdef TXCG_CONFIG_EN
      cfg_lat          <= cfg_lat_nxt;
      cfg_toggle       <= cfg_toggle_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    data_nxt   = enc_data;
    k_nxt      = enc_k;
    ind_nxt    = TX_OSET_indicate;
    rd_lat_nxt = rd_lat;
`ifdef TXCG_CONFIG_EN
    cfg_lat_nxt    = cfg_lat;
    cfg_toggle_nxt = cfg_toggle;
`endif
    if (TX_OSET_indicate) begin
      // Decision edge: a K28.5 set may only start when the next slot is even (current tx_even=0).
      state_nxt = GEN;
      ind_nxt   = 1'b1;
      k_nxt     = 1'b1;
      data_nxt  = K30_7;
      case (tx_o_set)
        OS_IDLE: begin
          if (!tx_even) begin
            state_nxt  = IDLE_K;
            data_nxt   = K28_5;
            ind_nxt    = 1'b0;
            rd_lat_nxt = rd_pos;
          end else begin
            data_nxt = K23_7;
          end
        end
        OS_S:    data_nxt = K27_7;
        OS_T:    data_nxt = K29_7;
        OS_R:    data_nxt = K23_7;
        OS_V:    data_nxt = K30_7;
        OS_DATA: begin
          data_nxt = TXD;
          k_nxt    = 1'b0;
        end
`ifdef TXCG_CONFIG_EN
        OS_CONFIG: begin
          if (!tx_even) begin
            state_nxt   = CFG_K;
            data_nxt    = K28_5;
            ind_nxt     = 1'b0;
            cfg_lat_nxt = cfg_reg;
          end else begin
            data_nxt = K23_7;
          end
        end
`endif
        default: data_nxt = K30_7;
      endcase
    end else begin
      case (state)
        IDLE_K: begin
          state_nxt = IDLE_D;
          data_nxt  = rd_lat ? I1_DATA : I2_DATA;
          k_nxt     = 1'b0;
          ind_nxt   = 1'b1;
        end
`ifdef TXCG_CONFIG_EN
        CFG_K: begin
          state_nxt = CFG_D;
          data_nxt  = cfg_toggle ? D2_2 : D21_5;
          k_nxt     = 1'b0;
          ind_nxt   = 1'b0;
        end
        CFG_D: begin
          state_nxt = CFG_LO;
          data_nxt  = cfg_lat[7:0];
          k_nxt     = 1'b0;
          ind_nxt   = 1'b0;
        end
        CFG_LO: begin
          state_nxt      = CFG_HI;
          data_nxt       = cfg_lat[15:8];
          k_nxt          = 1'b0;
          ind_nxt        = 1'b1;
          cfg_toggle_nxt = ~cfg_toggle;
        end
`endif
        default: begin
          // Unreachable mid-set state: recover with /V/ and a fresh decision.
          state_nxt = GEN;
          data_nxt  = K30_7;
          k_nxt     = 1'b1;
          ind_nxt   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/tx_code_group_ctrl.md
Name: tx_code_group_ctrl

Overview:
Transmit code-group sequencer for the 1000BASE-X PCS transmit path. It sits between TRANSMIT, which chooses the ordered set, and ENCODE, the 8b/10b encoder, and emits one code-group per GTX_CLK.
It owns tx_even parity and TX_OSET_indicate, and expands each requested ordered set into its code-group sequence. It picks I1 or I2 for /I/ from the encoder's running disparity and keeps every K28.5 on an even slot.

Parameters:
I1_DATA, 8'hC5, D5.6 second code-group of /I1/ (used when running disparity is positive).
I2_DATA, 8'h50, D16.2 second code-group of /I2/ (used when running disparity is negative).
CFG_W, 16, width of cfg_reg (config ordered-set payload).

Ports:
GTX_CLK  input  1  transmit clock; all state updates on rising edge.
mr_main_reset  input  1  asynchronous, active-high reset.
tx_o_set  input  3  ordered-set request from TRANSMIT: 0 IDLE, 1 /S/, 2 /T/, 3 /R/, 4 /V/, 5 DATA, 6 CONFIG, 7 reserved.
TXD  input  8  GMII data byte; used when tx_o_set=DATA.
rd_pos  input  1  running disparity from ENCODE, 1 = positive.
cfg_reg  input  CFG_W  config payload, low byte sent first.
enc_data  output  8  code-group octet to ENCODE.
enc_k  output  1  1 = control (K) code-group.
tx_even  output  1  1 = current code-group occupies an even slot.
TX_OSET_indicate  output  1  1 = current code-group is the last of its ordered set.

Behaviour:
- All outputs are registered.
- Reset values: enc_data=8'h00, enc_k=0, tx_even=0, TX_OSET_indicate=1, state=GEN, cfg_toggle=0.
- Reset is asynchronous: asserting it mid-set aborts the set immediately and forces the reset values.
- tx_even inverts on every GTX_CLK edge, unconditionally.
- Decision point: on an edge where TX_OSET_indicate=1, sample tx_o_set (and TXD) and start the new set; that set's first code-group appears on the outputs in the following cycle. Zero added latency between sets.
- The next slot is even when the current tx_even=0.
- States and sequences:
  - GEN: single-code-group sets, output with TX_OSET_indicate=1:
    - /S/ K27.7 = 8'hFB, k=1
    - /T/ K29.7 = 8'hFD, k=1
    - /R/ K23.7 = 8'hF7, k=1
    - /V/ K30.7 = 8'hFE, k=1
    - DATA: enc_data=TXD, k=0
    - tx_o_set=7: send /V/.
  - IDLE_K: K28.5 = 8'hBC, k=1, indicate=0; go to IDLE_D. rd_pos is latched on this edge.
  - IDLE_D: I1_DATA if the latched rd_pos=1, else I2_DATA; k=0, indicate=1.
  - CFG_K → CFG_D → CFG_LO → CFG_HI (CONFIG option only):
    - CFG_K: K28.5.
    - CFG_D: D21.5 = 8'hB5 when cfg_toggle=0 (/C1/), else D2.2 = 8'h42 (/C2/).
    - CFG_LO: cfg_reg[7:0].
    - CFG_HI: cfg_reg[15:8], indicate=1.
    - cfg_reg is captured at the decision edge, and cfg_toggle flips after each completed /C/.
- Alignment: IDLE or CONFIG requested when the next slot is odd → send one /R/ filler with indicate=1 and no other state change; the request is re-sampled on the next edge. K28.5 never appears with tx_even=0.
- tx_o_set changing while indicate=0 is ignored.

Optional Feature:
TXCG_CONFIG_EN:
- Defined: CONFIG (6) is supported as above, including alignment.
- Undefined: CONFIG is treated as /V/, cfg_reg is ignored (the port is retained), the CFG_* states and cfg_toggle are absent, and /C/ is never emitted.

Test Plan:
1. Reset held, then released with tx_o_set=IDLE and rd_pos=0 → first cycle BC/k1/even1/ind0, second cycle 50/k0/even0/ind1; the pair repeats.
2. IDLE with rd_pos=1 at the K28.5 edge → second code-group C5; rd_pos toggled during the D cycle has no effect.
3. Packet: IDLE, then /S/, DATA 00, 01, 9A, B5, 42, then /T/, /R/, IDLE → FB, 00, 01, 9A, B5, 42, FD, F7 each with ind1; if IDLE lands on an odd slot, one extra F7 precedes BC.
4. tx_o_set=7 → FE/k1.
5. Reset asserted in the IDLE_K cycle → outputs go to reset values asynchronously, before the next edge.
6. With TXCG_CONFIG_EN and cfg_reg=16'h01A5 → BC, B5, A5, 01, then BC, 42, A5, 01. Without the macro → FE.
